// File: rtl/custom_vec_write_seq.sv
// Write-side sequencer for the custom vector word store: takes a (start, length) command and
// a valid/ready beat stream, issuing one registered write per accepted beat with modulo wrap.
module custom_vec_write_seq #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned NumWords = 512,
   localparam int unsigned AddrW   = $clog2(NumWords)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [AddrW-1:0]  cmd_addr_i,
   input  logic [AddrW:0]    cmd_len_i,
   input  logic              data_valid_i,
   output logic              data_ready_o,
   input  logic [XLEN-1:0]   data_i,
   input  logic [XLEN/8-1:0] be_i,
   output logic              we_o,
   output logic [AddrW-1:0]  waddr_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN/8-1:0] wbe_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [AddrW:0]   NumWordsW = (AddrW+1)'(NumWords);
   localparam logic [AddrW-1:0] LastAddr  = AddrW'(NumWords - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e             state_q, state_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [AddrW:0]     cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [AddrW-1:0]   waddr_q, waddr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [XLEN/8-1:0]  wbe_q, wbe_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic cmd_fire, data_fire, cmd_legal;

   assign cmd_ready_o  = (state_q == IDLE) & ~flush_i;
   assign data_ready_o = (state_q == RUN) & ~flush_i;
   assign cmd_fire     = cmd_valid_i & cmd_ready_o;
   assign data_fire    = data_valid_i & data_ready_o;
   assign cmd_legal    = (cmd_len_i != '0) && (cmd_len_i <= NumWordsW) &&
                         ({1'b0, cmd_addr_i} < NumWordsW);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wbe_d   = wbe_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (cmd_legal) begin
                  state_d = RUN;
                  addr_d  = cmd_addr_i;
                  cnt_d   = cmd_len_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (data_fire) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = data_i;
               wbe_d   = be_i;
               addr_d  = (addr_q == LastAddr) ? '0 : addr_q + AddrW'(1);
               cnt_d   = cnt_q - (AddrW+1)'(1);
               // done is registered so it lines up with the final write strobe
               if (cnt_q == (AddrW+1)'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wbe_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wbe_q   <= wbe_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign wbe_o   = wbe_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign busy_o  = (state_q == RUN) | we_q;

endmodule

// File: tb/tb_custom_vec_write_seq.sv
// Directed bench for custom_vec_write_seq: a 512-word instance plus a 6-word instance
// for non-power-of-two wrap and out-of-range start addresses.
module tb_custom_vec_write_seq;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_addr;
   logic [9:0]  cmd_len;
   logic        data_valid;
   logic        data_ready;
   logic [63:0] data;
   logic [7:0]  be;
   logic        we;
   logic [8:0]  waddr;
   logic [63:0] wdata;
   logic [7:0]  wbe;
   logic        busy;
   logic        done;
   logic        err;

   logic        s_flush;
   logic        s_cmd_valid;
   logic        s_cmd_ready;
   logic [2:0]  s_cmd_addr;
   logic [3:0]  s_cmd_len;
   logic        s_data_valid;
   logic        s_data_ready;
   logic        s_we;
   logic [2:0]  s_waddr;
   logic [63:0] s_wdata;
   logic [7:0]  s_wbe;
   logic        s_busy;
   logic        s_done;
   logic        s_err;

   int n_checks;
   int n_errors;

   custom_vec_write_seq #(.XLEN(64), .NumWords(512)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .data_valid_i(data_valid), .data_ready_o(data_ready),
      .data_i(data), .be_i(be),
      .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .wbe_o(wbe),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   custom_vec_write_seq #(.XLEN(64), .NumWords(6)) dut_small (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(s_flush),
      .cmd_valid_i(s_cmd_valid), .cmd_ready_o(s_cmd_ready),
      .cmd_addr_i(s_cmd_addr), .cmd_len_i(s_cmd_len),
      .data_valid_i(s_data_valid), .data_ready_o(s_data_ready),
      .data_i(data), .be_i(be),
      .we_o(s_we), .waddr_o(s_waddr), .wdata_o(s_wdata), .wbe_o(s_wbe),
      .busy_o(s_busy), .done_o(s_done), .err_o(s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [8:0]  exp_addr2 [4];
   int          gap_valid [5];
   logic [63:0] gap_data  [5];
   logic [7:0]  gap_be    [5];
   logic [8:0]  gap_addr  [5];
   logic [2:0]  small_addr [3];
   int          done_cnt;

   initial begin
      rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      data_valid = 1'b0; data = '0; be = '0;
      s_flush = 1'b0; s_cmd_valid = 1'b0; s_cmd_addr = '0; s_cmd_len = '0; s_data_valid = 1'b0;
      n_checks = 0; n_errors = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_data_ready", data_ready, 0);
      check("rst_we", we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      // basic command: 4 beats from word 5
      cmd_valid = 1'b1; cmd_addr = 9'd5; cmd_len = 10'd4;
      #1 check("s1_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check("s1_run_data_ready", data_ready, 1);
      check("s1_run_cmd_ready", cmd_ready, 0);
      check("s1_run_busy", busy, 1);
      check("s1_run_we", we, 0);
      for (int i = 0; i < 4; i++) begin
         data_valid = 1'b1; data = 64'hA5A5_0000_0000_0000 | 64'(i); be = 8'hFF;
         tick();
         check("s1_we", we, 1);
         check("s1_waddr", waddr, 64'(5 + i));
         check("s1_wdata", wdata, 64'hA5A5_0000_0000_0000 | 64'(i));
         check("s1_wbe", wbe, 8'hFF);
         check("s1_done", done, (i == 3) ? 1 : 0);
      end
      data_valid = 1'b0;
      check("s1_last_cmd_ready", cmd_ready, 1);
      check("s1_last_busy", busy, 1);
      tick();
      check("s1_after_we", we, 0);
      check("s1_after_done", done, 0);
      check("s1_after_busy", busy, 0);

      // wrap through the top of the store
      exp_addr2[0] = 9'd510; exp_addr2[1] = 9'd511; exp_addr2[2] = 9'd0; exp_addr2[3] = 9'd1;
      cmd_valid = 1'b1; cmd_addr = 9'd510; cmd_len = 10'd4;
      tick();
      cmd_valid = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         data_valid = 1'b1; data = 64'h1111_0000 + 64'(i); be = 8'h0F;
         tick();
         check("s2_we", we, 1);
         check("s2_waddr", waddr, exp_addr2[i]);
         if (done) done_cnt++;
      end
      data_valid = 1'b0;
      tick();
      if (done) done_cnt++;
      check("s2_done_count", done_cnt, 1);
      check("s2_after_we", we, 0);

      // illegal commands, with data offered while idle
      cmd_valid = 1'b1; cmd_addr = 9'd7; cmd_len = 10'd0; data_valid = 1'b1;
      tick();
      check("s3_len0_err", err, 1);
      check("s3_len0_we", we, 0);
      check("s3_len0_cmd_ready", cmd_ready, 1);
      check("s3_len0_data_ready", data_ready, 0);
      cmd_len = 10'd513;
      tick();
      check("s3_len513_err", err, 1);
      check("s3_len513_we", we, 0);
      check("s3_len513_busy", busy, 0);
      cmd_valid = 1'b0; data_valid = 1'b0;
      tick();
      check("s3_err_clear", err, 0);
      check("s3_idle_we", we, 0);

      // gaps in the data stream
      gap_valid[0] = 1; gap_data[0] = 64'hAAAA; gap_be[0] = 8'h0F; gap_addr[0] = 9'd100;
      gap_valid[1] = 0; gap_data[1] = 64'hDEAD; gap_be[1] = 8'h00; gap_addr[1] = 9'd0;
      gap_valid[2] = 0; gap_data[2] = 64'hDEAD; gap_be[2] = 8'h00; gap_addr[2] = 9'd0;
      gap_valid[3] = 1; gap_data[3] = 64'hBBBB; gap_be[3] = 8'hF0; gap_addr[3] = 9'd101;
      gap_valid[4] = 1; gap_data[4] = 64'hCCCC; gap_be[4] = 8'h3C; gap_addr[4] = 9'd102;
      cmd_valid = 1'b1; cmd_addr = 9'd100; cmd_len = 10'd3;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data_valid = (gap_valid[i] != 0); data = gap_data[i]; be = gap_be[i];
         tick();
         check("s4_we", we, 64'(gap_valid[i]));
         if (gap_valid[i] != 0) begin
            check("s4_waddr", waddr, gap_addr[i]);
            check("s4_wdata", wdata, gap_data[i]);
            check("s4_wbe", wbe, gap_be[i]);
         end
         check("s4_done", done, (i == 4) ? 1 : 0);
      end
      data_valid = 1'b0;
      tick();
      check("s4_after_we", we, 0);
      check("s4_after_busy", busy, 0);

      // flush after the third handshake of an 8-word command
      cmd_valid = 1'b1; cmd_addr = 9'd20; cmd_len = 10'd8;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_valid = 1'b1; data = 64'h5000 + 64'(i); be = 8'hFF;
         tick();
         check("s5_we", we, 1);
         check("s5_waddr", waddr, 64'(20 + i));
      end
      flush = 1'b1; data = 64'h5003; cmd_valid = 1'b1; cmd_addr = 9'd0; cmd_len = 10'd1;
      #1;
      check("s5_flush_data_ready", data_ready, 0);
      check("s5_flush_cmd_ready", cmd_ready, 0);
      check("s5_flush_busy", busy, 1);
      tick();
      check("s5_post_we", we, 0);
      check("s5_post_done", done, 0);
      check("s5_post_err", err, 0);
      flush = 1'b0; data_valid = 1'b0;
      #1;
      check("s5_post_cmd_ready", cmd_ready, 1);
      check("s5_post_busy", busy, 0);
      tick();
      cmd_valid = 1'b0;
      check("s5_next_data_ready", data_ready, 1);
      data_valid = 1'b1; data = 64'h7777; be = 8'h01;
      tick();
      check("s5_next_we", we, 1);
      check("s5_next_waddr", waddr, 0);
      check("s5_next_wdata", wdata, 64'h7777);
      check("s5_next_wbe", wbe, 8'h01);
      check("s5_next_done", done, 1);
      data_valid = 1'b0;
      tick();

      // asynchronous reset mid-command
      cmd_valid = 1'b1; cmd_addr = 9'd40; cmd_len = 10'd5;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         data_valid = 1'b1; data = 64'h9000 + 64'(i); be = 8'hFF;
         tick();
      end
      check("s6_pre_we", we, 1);
      check("s6_pre_waddr", waddr, 41);
      rst_n = 1'b0;
      #1;
      check("s6_rst_we", we, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_cmd_ready", cmd_ready, 1);
      check("s6_rst_data_ready", data_ready, 0);
      check("s6_rst_waddr", waddr, 0);
      check("s6_rst_wdata", wdata, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("s6_rel_we", we, 0);
      check("s6_rel_data_ready", data_ready, 0);
      tick();
      check("s6_rel2_we", we, 0);
      data_valid = 1'b0;

      // 6-word store: out-of-range start, oversize length, non-power-of-two wrap
      s_cmd_valid = 1'b1; s_cmd_addr = 3'd6; s_cmd_len = 4'd1;
      tick();
      check("s7_addr6_err", s_err, 1);
      check("s7_addr6_we", s_we, 0);
      s_cmd_addr = 3'd3; s_cmd_len = 4'd7;
      tick();
      check("s7_len7_err", s_err, 1);
      check("s7_len7_data_ready", s_data_ready, 0);
      small_addr[0] = 3'd4; small_addr[1] = 3'd5; small_addr[2] = 3'd0;
      s_cmd_addr = 3'd4; s_cmd_len = 4'd3;
      tick();
      s_cmd_valid = 1'b0;
      check("s7_legal_err", s_err, 0);
      check("s7_legal_data_ready", s_data_ready, 1);
      for (int i = 0; i < 3; i++) begin
         s_data_valid = 1'b1; data = 64'hE000 + 64'(i); be = 8'hAA;
         tick();
         check("s7_we", s_we, 1);
         check("s7_waddr", s_waddr, small_addr[i]);
         check("s7_wdata", s_wdata, 64'hE000 + 64'(i));
         check("s7_done", s_done, (i == 2) ? 1 : 0);
      end
      s_data_valid = 1'b0;
      tick();
      check("s7_after_we", s_we, 0);
      check("s7_after_busy", s_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
